// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between ALU issue logic (master) and the
// shared-adder arbiter (slave).
interface adder_share_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 32,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_cin;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_sum;
   logic              rsp_cout;
   logic              rsp_ovf;

   modport master (
      output req_valid, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
   );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one external W-bit adder among NREQ requesters.
// Define ADDER_ARB_SAT_EN to saturate rsp_sum on signed overflow.
module adder_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 32,
   parameter int ADD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   adder_share_arbiter_if.slave ifc,
   output logic [W-1:0]         add_a,
   output logic [W-1:0]         add_b,
   output logic                 add_cin,
   input  logic [W-1:0]         add_sum,
   input  logic                 add_cout,
   output logic                 busy
);
   localparam int IDW    = $clog2(NREQ);
   localparam int LAST_I = NREQ - 1;
   localparam int ONE_I  = 1;
   localparam logic [IDW:0]   NREQ_W  = NREQ[IDW:0];
   localparam logic [IDW-1:0] LAST_ID = LAST_I[IDW-1:0];
   localparam logic [IDW-1:0] ONE_ID  = ONE_I[IDW-1:0];
   localparam logic [3:0]     LAT_W   = ADD_LAT[3:0];

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state_reg, state_next;

   logic [IDW-1:0] ptr_reg, id_reg, winner;
   logic [W-1:0]   a_reg, b_reg, sum_reg, sum_next;
   logic           cin_reg, cout_reg, ovf_reg, valid_reg, ovf_next;
   logic [3:0]     cnt_reg;
   logic           found, accept, capture, release_rsp;
   logic [NREQ-1:0] rot_valid;
   logic [IDW:0]    rot_idx [NREQ];
   logic [W-1:0]    a_arr   [NREQ];
   logic [W-1:0]    b_arr   [NREQ];

   // rot_idx[gi] is the requester examined gi places after the rr pointer
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      localparam int OFF_I = gi;
      localparam logic [IDW:0] OFF = OFF_I[IDW:0];
      logic [IDW:0] raw;
      assign raw           = {1'b0, ptr_reg} + OFF;
      assign rot_idx[gi]   = (raw >= NREQ_W) ? raw - NREQ_W : raw;
      assign rot_valid[gi] = ifc.req_valid[rot_idx[gi][IDW-1:0]];
      assign a_arr[gi]     = ifc.req_a[gi*W +: W];
      assign b_arr[gi]     = ifc.req_b[gi*W +: W];
   end

   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            found  = 1'b1;
            winner = rot_idx[k][IDW-1:0];
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      accept        = 1'b0;
      capture       = 1'b0;
      release_rsp   = 1'b0;
      ifc.req_ready = '0;
      case (state_reg)
         IDLE: begin
            if (found && rst_n) begin
               ifc.req_ready[winner] = 1'b1;
               accept                = 1'b1;
               state_next            = WAIT;
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd1) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (ifc.rsp_ready) begin
               release_rsp = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Overflow is judged from the latched operands, not the live requester bus
   assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (add_sum[W-1] != a_reg[W-1]);

`ifdef ADDER_ARB_SAT_EN
   assign sum_next = !ovf_next  ? add_sum :
                     a_reg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
   assign sum_next = add_sum;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_reg   <= '0;
         id_reg    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         cin_reg   <= 1'b0;
         cnt_reg   <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            a_reg   <= a_arr[winner];
            b_reg   <= b_arr[winner];
            cin_reg <= ifc.req_cin[winner];
            id_reg  <= winner;
            cnt_reg <= LAT_W;
         end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_reg - 4'd1;
         end
         if (capture) begin
            sum_reg   <= sum_next;
            cout_reg  <= add_cout;
            ovf_reg   <= ovf_next;
            valid_reg <= 1'b1;
         end
         if (release_rsp) begin
            valid_reg <= 1'b0;
            ptr_reg   <= (id_reg == LAST_ID) ? '0 : id_reg + ONE_ID;
         end
      end
   end

   assign add_a         = a_reg;
   assign add_b         = b_reg;
   assign add_cin       = cin_reg;
   assign ifc.rsp_valid = valid_reg;
   assign ifc.rsp_id    = id_reg;
   assign ifc.rsp_sum   = sum_reg;
   assign ifc.rsp_cout  = cout_reg;
   assign ifc.rsp_ovf   = ovf_reg;
   assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench: vector table, hand-written corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_adder_share_arbiter;
   localparam int NREQ    = 4;
   localparam int W       = 32;
   localparam int ADD_LAT = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic [W-1:0] add_a, add_b, add_sum;
   logic add_cin, add_cout, busy;

   int errors = 0;
   int checks = 0;
   int mptr   = 0;
   logic [31:0] op_a [NREQ];
   logic [31:0] op_b [NREQ];
   logic        op_c [NREQ];

   adder_share_arbiter_if #(.NREQ(NREQ), .W(W)) ifc ();

   adder_share_arbiter #(.NREQ(NREQ), .W(W), .ADD_LAT(ADD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .ifc(ifc),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
   );

   always #5 clk = ~clk;

   // external adder whose result settles one cycle after its operands change
   always @(posedge clk) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

   typedef struct {
      logic [31:0] a, b;
      logic        cin;
      logic [31:0] sum;
      logic        cout, ovf;
   } vec_t;
   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic void ref_add(input logic [31:0] a, input logic [31:0] b, input logic c,
                                   output logic [31:0] s, output logic co, output logic ov);
      logic [32:0] u;
      longint sg;
      u  = {1'b0, a} + {1'b0, b} + {32'd0, c};
      sg = longint'($signed(a)) + longint'($signed(b)) + (c ? 64'sd1 : 64'sd0);
      s  = u[31:0];
      co = u[32];
      ov = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
`ifdef ADDER_ARB_SAT_EN
      if (ov) s = (sg > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return 32'h00000000;
         1: return 32'hFFFFFFFF;
         2: return 32'h7FFFFFFF;
         3: return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   task automatic pack();
      for (int i = 0; i < NREQ; i++) begin
         ifc.req_a[i*W +: W] = op_a[i];
         ifc.req_b[i*W +: W] = op_b[i];
         ifc.req_cin[i]      = op_c[i];
      end
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      ifc.req_valid = '1;
      ifc.rsp_ready = 1'b0;
      tick();
      tick();
      check("rst_req_ready_gated", 64'(ifc.req_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      ifc.req_valid = '0;
      rst_n = 1'b1;
      #1;
      check("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
      check("rst_add_a", 64'(add_a), 64'd0);
      check("rst_add_b", 64'(add_b), 64'd0);
      check("rst_add_cin", 64'(add_cin), 64'd0);
      check("rst_rsp_sum", 64'(ifc.rsp_sum), 64'd0);
      mptr = 0;
   endtask

   // One full request/response; expected winner and result come from the model.
   task automatic do_txn(input logic [3:0] mask, input logic [3:0] pend, input int stall,
                         output int gid, output logic [31:0] s, output logic co, output logic ov);
      int exp_id, n, lat, g;
      logic [31:0] es, ea;
      logic eco, eov;
      exp_id = -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (mptr + k) % NREQ;
         if (exp_id < 0 && mask[idx]) exp_id = idx;
      end
      ifc.req_valid = mask;
      pack();
      #1;
      n = 0;
      while (ifc.req_ready == '0 && n < 50) begin
         tick();
         n++;
      end
      check("grant_seen", 64'(ifc.req_ready != '0), 64'd1);
      check("grant_onehot", 64'($countones(ifc.req_ready)), 64'd1);
      gid = -1;
      for (int k = 0; k < NREQ; k++) if (ifc.req_ready[k]) gid = k;
      check("grant_id", 64'(gid), 64'(exp_id));
      g = (gid < 0) ? 0 : gid;
      ea = op_a[g];
      ref_add(op_a[g], op_b[g], op_c[g], es, eco, eov);
      tick();
      ifc.req_valid = pend;
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = $urandom;
         op_b[i] = $urandom;
      end
      pack();
      check("add_a_latched", 64'(add_a), 64'(ea));
      lat = 0;
      while (!ifc.rsp_valid && lat < 50) begin
         tick();
         lat++;
      end
      check("latency", 64'(lat), 64'(ADD_LAT));
      check("rsp_id", 64'(ifc.rsp_id), 64'(g));
      check("rsp_sum", 64'(ifc.rsp_sum), 64'(es));
      check("rsp_cout", 64'(ifc.rsp_cout), 64'(eco));
      check("rsp_ovf", 64'(ifc.rsp_ovf), 64'(eov));
      s  = ifc.rsp_sum;
      co = ifc.rsp_cout;
      ov = ifc.rsp_ovf;
      for (int i = 0; i < stall; i++) begin
         check("stall_busy", 64'(busy), 64'd1);
         check("stall_req_ready", 64'(ifc.req_ready), 64'd0);
         tick();
      end
      if (stall > 0) begin
         check("stall_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
         check("stall_rsp_sum", 64'(ifc.rsp_sum), 64'(s));
      end
      ifc.rsp_ready = 1'b1;
      #1;
      check("hs_req_ready", 64'(ifc.req_ready), 64'd0);
      tick();
      ifc.rsp_ready = 1'b0;
      #1;
      check("rsp_valid_drop", 64'(ifc.rsp_valid), 64'd0);
      if (pend != '0) check("pend_accept", 64'(ifc.req_ready != '0), 64'd1);
      mptr = (g + 1) % NREQ;
      $display("txn mask=%b id=%0d a=%08h sum=%08h cout=%0d ovf=%0d lat=%0d stall=%0d",
               mask, gid, ea, s, co, ov, lat, stall);
   endtask

   initial begin
      int gid, n, seen;
      logic [31:0] s;
      logic co, ov;
      int g_id[$], g_cyc[$], r_id[$];

      rst_n = 1'b0;
      ifc.req_valid = '0;
      ifc.rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
         op_c[i] = 1'b0;
      end
      pack();

`ifdef ADDER_ARB_SAT_EN
      vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
      vecs[1] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
      vecs[3] = '{32'h5A3F2D1C, 32'h4C7E9A8B, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
      vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b1};
`else
      vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[1] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
      vecs[3] = '{32'h5A3F2D1C, 32'h4C7E9A8B, 1'b1, 32'hA6BDC7A8, 1'b0, 1'b1};
      vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
`endif
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
      vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};

      reset_dut();

      // vector table on requester 0
      for (int i = 0; i < 6; i++) begin
         op_a[0] = vecs[i].a;
         op_b[0] = vecs[i].b;
         op_c[0] = vecs[i].cin;
         do_txn(4'b0001, 4'b0000, 0, gid, s, co, ov);
         check("vec_sum", 64'(s), 64'(vecs[i].sum));
         check("vec_cout", 64'(co), 64'(vecs[i].cout));
         check("vec_ovf", 64'(ov), 64'(vecs[i].ovf));
      end

      // all requesters held valid from reset, consumer always ready
      reset_dut();
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = $urandom;
         op_b[i] = $urandom;
      end
      pack();
      ifc.req_valid = '1;
      ifc.rsp_ready = 1'b1;
      #1;
      for (int c = 0; c < 20; c++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (ifc.req_ready[k]) begin
               g_id.push_back(k);
               g_cyc.push_back(c);
               $display("grant cycle=%0d id=%0d", c, k);
            end
         end
         if (ifc.rsp_valid) r_id.push_back(int'(ifc.rsp_id));
         tick();
      end
      check("rr_grant_count", 64'(g_id.size()), 64'd5);
      check("rr_rsp_count", 64'(r_id.size()), 64'd5);
      for (int i = 0; i < 5 && i < g_id.size(); i++) begin
         check("rr_grant_order", 64'(g_id[i]), 64'(i % NREQ));
         check("rr_grant_cycle", 64'(g_cyc[i]), 64'(i * (ADD_LAT + 2)));
         if (i < r_id.size()) check("rr_rsp_id", 64'(r_id[i]), 64'(g_id[i]));
      end
      ifc.req_valid = '0;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      ifc.rsp_ready = 1'b0;

      // pointer wrap after serving the last requester
      reset_dut();
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = rnd_op();
         op_b[i] = rnd_op();
         op_c[i] = 1'($urandom_range(0, 1));
      end
      do_txn(4'b1000, 4'b0000, 0, gid, s, co, ov);
      check("wrap_first", 64'(gid), 64'd3);
      do_txn(4'b1010, 4'b0000, 0, gid, s, co, ov);
      check("wrap_grant1", 64'(gid), 64'd1);
      do_txn(4'b1010, 4'b0000, 0, gid, s, co, ov);
      check("wrap_grant3", 64'(gid), 64'd3);

      // response back-pressure with a request waiting behind it
      op_a[0] = 32'h12345678; op_b[0] = 32'h11111111; op_c[0] = 1'b0;
      do_txn(4'b0001, 4'b0100, 5, gid, s, co, ov);
      op_a[2] = 32'hDEADBEEF; op_b[2] = 32'h21524111; op_c[2] = 1'b1;
      do_txn(4'b0100, 4'b0000, 0, gid, s, co, ov);
      check("bp_next_id", 64'(gid), 64'd2);

      // reset asserted mid-operation
      op_a[0] = 32'hCAFEF00D; op_b[0] = 32'h01010101; op_c[0] = 1'b0;
      pack();
      ifc.req_valid = 4'b0001;
      #1;
      n = 0;
      while (ifc.req_ready == '0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      ifc.req_valid = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
      check("abort_add_a", 64'(add_a), 64'd0);
      check("abort_add_b", 64'(add_b), 64'd0);
      check("abort_add_cin", 64'(add_cin), 64'd0);
      seen = 0;
      ifc.rsp_ready = 1'b1;
      repeat (8) begin
         tick();
         if (ifc.rsp_valid) seen = 1;
      end
      ifc.rsp_ready = 1'b0;
      check("abort_no_rsp", 64'(seen), 64'd0);
      mptr = 0;
      op_a[2] = 32'h00000005; op_b[2] = 32'h00000007; op_c[2] = 1'b1;
      do_txn(4'b0100, 4'b0000, 1, gid, s, co, ov);
      check("abort_next_id", 64'(gid), 64'd2);

      // randomized traffic
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < NREQ; i++) begin
            op_a[i] = rnd_op();
            op_b[i] = rnd_op();
            op_c[i] = 1'($urandom_range(0, 1));
         end
         do_txn(4'($urandom_range(1, 15)), 4'b0000, $urandom_range(0, 3), gid, s, co, ov);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
